accumulator_readout: RTL and testbench
======================================

ACCUMULATOR_READOUT -- requirements
Module: accumulator_readout

Interface
REQ-001 SHALL import tpu_package; accumulator lane width is RES_WIDTH+1 bits signed; lane count fixed at 32.
REQ-002 SHALL have parameter OUT_WIDTH, default 8, meaning signed output lane width written to the unified buffer.
REQ-003 SHALL have ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous active-high reset.
- start_i  in  1  job request; sampled only in IDLE.
- num_rows_i  in  8  rows to drain, 0..128.
- acc_base_i  in  7  first accumulator row.
- ub_base_i  in  7  first unified-buffer row.
- shift_i  in  5  arithmetic right-shift amount.
- relu_en_i  in  1  clamp negatives to 0 before shifting.
- acc_data_i  in  [32][RES_WIDTH:0]  accumulator read data (diagonal-skewed).
- acc_rd_en_o  out  1  accumulator port-1 read enable.
- acc_addr_rd_o  out  7  accumulator read address.
- ub_wr_en_o  out  1  unified-buffer write strobe.
- ub_addr_o  out  7  unified-buffer write address.
- ub_data_o  out  [32][OUT_WIDTH-1:0]  activated row.
- busy_o  out  1  job in progress.
- done_o  out  1  one-cycle completion pulse.

Function
REQ-004 SHALL latch num_rows_i, acc_base_i, ub_base_i, shift_i and relu_en_i at the start-accept edge; later changes SHALL NOT affect the running job.
REQ-005 SHALL implement the FSM IDLE -> READ -> DRAIN -> DONE -> IDLE.
- IDLE->READ on start_i with N>0.
- IDLE->DONE on start_i with N=0.
- READ->DRAIN after N+31 read cycles.
- DRAIN->DONE after the last write.
- DONE->IDLE unconditionally.
REQ-006 Cycle 0 SHALL be the first READ cycle. During cycles c=0..N+30: acc_rd_en_o=1 and acc_addr_rd_o=(acc_base+c) mod 128. Outside READ, both SHALL be 0.
REQ-007 SHALL treat acc_data_i as one-cycle read latency with lane skew: during cycle j+k+1, lane k carries row j.
REQ-008 SHALL deskew by delaying lane k by 31-k register stages (lane 31 undelayed), so every lane of row j is aligned at cycle j+32.
REQ-009 SHALL apply activation per lane in one registered stage, in this order:
- x = relu_en && x<0 ? 0 : x;
- y = x >>> shift (floor, sign-extending);
- saturate y to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
REQ-010 For row j (j=0..N-1), SHALL assert ub_wr_en_o in cycle j+33 with ub_addr_o=(ub_base+j) mod 128 and ub_data_o holding the activated lanes.
REQ-011 SHALL write exactly N rows, consecutively and in order; ramp-up and drain lanes SHALL never be written.
REQ-012 ub_addr_o and ub_data_o SHALL be 0 whenever ub_wr_en_o=0.
REQ-013 busy_o SHALL be 1 from cycle 0 through the last write cycle, and 0 in IDLE and DONE.
REQ-014 done_o SHALL pulse for exactly 1 cycle:
- in cycle N+33 for N>0;
- in the cycle after acceptance for N=0.
REQ-015 SHALL ignore start_i while not IDLE, including the DONE cycle.
REQ-016 num_rows_i>128 SHALL be clamped to 128.
REQ-017 Address wrap past 127 SHALL go to 0 on both ports.

Reset
REQ-018 While rst_i=1 at a clock edge, SHALL return to IDLE and clear all deskew and activation registers.
REQ-019 Reset values: all outputs 0.
REQ-020 Reset mid-job SHALL abort with no further reads or writes and no done_o pulse; a start_i in the first cycle after reset release SHALL be accepted.

Verification
REQ-021 Bench SHALL cover:
- Deskew: N=4, acc_base=0, ub_base=10, shift=0, relu off, row j lane k=j*32+k (fits) -> writes at cycles 33..36, addresses 10..13, lane k of write j = sat(j*32+k); done_o at cycle 37.
- Arithmetic: lane values 1000/2000/-40/-5000 with shift=3, relu off -> 125 / 127 (saturated) / -5 / -128 (saturated).
- ReLU: same values with shift=3, relu on -> 125 / 127 / 0 / 0.
- Wrap: N=3, acc_base=126, ub_base=127 -> reads at addresses 126,127,0..31; writes at addresses 127,0,1.
- Control: N=0 -> no reads or writes, done_o in the cycle after start; start_i held high throughout an N=2 job -> a second job begins only after the DONE cycle.
- Reset at cycle 20 of an N=8 job -> acc_rd_en_o, ub_wr_en_o, busy_o and done_o all 0 thereafter; a new N=1 job then completes normally.

Source files
------------

// File: rtl/tpu_package.sv
`default_nettype none
// ============================================================================
// tpu_package: shared TPU datapath widths
// Rev 1.0
// ============================================================================
package tpu_package;
  localparam int RES_WIDTH = 20;
endpackage
`default_nettype wire

// File: rtl/accumulator_readout_if.sv
`default_nettype none
// ============================================================================
// accumulator_readout_if: job control, accumulator read and UB write bundle
// Rev 1.0
// ============================================================================
interface accumulator_readout_if #(
  parameter int OUT_WIDTH = 8
);
  import tpu_package::*;

  logic                          start_i;
  logic [7:0]                    num_rows_i;
  logic [6:0]                    acc_base_i;
  logic [6:0]                    ub_base_i;
  logic [4:0]                    shift_i;
  logic                          relu_en_i;
  logic [31:0][RES_WIDTH:0]      acc_data_i;
  logic                          acc_rd_en_o;
  logic [6:0]                    acc_addr_rd_o;
  logic                          ub_wr_en_o;
  logic [6:0]                    ub_addr_o;
  logic [31:0][OUT_WIDTH-1:0]    ub_data_o;
  logic                          busy_o;
  logic                          done_o;

  modport master (
    output start_i, num_rows_i, acc_base_i, ub_base_i, shift_i, relu_en_i, acc_data_i,
    input  acc_rd_en_o, acc_addr_rd_o, ub_wr_en_o, ub_addr_o, ub_data_o, busy_o, done_o
  );

  modport slave (
    input  start_i, num_rows_i, acc_base_i, ub_base_i, shift_i, relu_en_i, acc_data_i,
    output acc_rd_en_o, acc_addr_rd_o, ub_wr_en_o, ub_addr_o, ub_data_o, busy_o, done_o
  );
endinterface
`default_nettype wire

// File: rtl/accumulator_readout.sv
`default_nettype none
// ============================================================================
// accumulator_readout: drain accumulator rows, deskew, activate, write to UB
// Rev 1.0
// ============================================================================
module accumulator_readout
  import tpu_package::*;
#(
  parameter int OUT_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  accumulator_readout_if.slave bus
);

  localparam int LANES = 32;

  typedef logic signed [RES_WIDTH:0]   acc_t;
  typedef logic signed [OUT_WIDTH-1:0] out_t;
  typedef logic [LANES-1:0][OUT_WIDTH-1:0] row_t;

  localparam acc_t SAT_MAX = acc_t'((2 ** (OUT_WIDTH - 1)) - 1);
  localparam acc_t SAT_MIN = acc_t'(-(2 ** (OUT_WIDTH - 1)));

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [8:0] cyc_q, cyc_d;
  logic [7:0] num_rows_q, num_rows_d;
  logic [6:0] acc_base_q, acc_base_d;
  logic [6:0] ub_base_q, ub_base_d;
  logic [4:0] shift_q, shift_d;
  logic       relu_q, relu_d;
  logic       wr_en_q, wr_en_d;
  logic [6:0] ub_addr_q, ub_addr_d;
  row_t       ub_data_q, ub_data_d;

  logic [7:0] rows_clamped;
  logic [8:0] row_idx;
  logic       row_valid;
  logic       rd_active;
  acc_t       aligned [LANES];

  function automatic out_t activate(input acc_t x_in, input logic [4:0] sh, input logic relu);
    acc_t x;
    acc_t y;
    out_t res;
    x = (relu && x_in[RES_WIDTH]) ? '0 : x_in;
    y = x >>> sh;
    if (y > SAT_MAX) begin
      res = out_t'(SAT_MAX);
    end else if (y < SAT_MIN) begin
      res = out_t'(SAT_MIN);
    end else begin
      res = out_t'(y);
    end
    return res;
  endfunction

  // Lane k arrives k cycles after lane 0, so it is held 31-k cycles to line rows up.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    if (k == LANES - 1) begin : g_direct
      assign aligned[k] = $signed(bus.acc_data_i[k]);
    end else begin : g_delay
      localparam int DEPTH = LANES - 1 - k;
      acc_t pipe_q [DEPTH];
      acc_t pipe_d [DEPTH];

      always_comb begin
        pipe_d[0] = $signed(bus.acc_data_i[k]);
        for (int i = 1; i < DEPTH; i++) begin
          pipe_d[i] = pipe_q[i-1];
        end
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          for (int i = 0; i < DEPTH; i++) begin
            pipe_q[i] <= '0;
          end
        end else begin
          pipe_q <= pipe_d;
        end
      end

      assign aligned[k] = pipe_q[DEPTH-1];
    end
  end

  assign rows_clamped = (bus.num_rows_i > 8'd128) ? 8'd128 : bus.num_rows_i;
  assign rd_active    = (state_q == S_READ);
  assign row_idx      = cyc_q - 9'd32;
  assign row_valid    = ((state_q == S_READ) || (state_q == S_DRAIN)) &&
                        (cyc_q >= 9'd32) && (row_idx < {1'b0, num_rows_q});

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    num_rows_d = num_rows_q;
    acc_base_d = acc_base_q;
    ub_base_d  = ub_base_q;
    shift_d    = shift_q;
    relu_d     = relu_q;
    unique case (state_q)
      S_IDLE: begin
        cyc_d = '0;
        if (bus.start_i) begin
          num_rows_d = rows_clamped;
          acc_base_d = bus.acc_base_i;
          ub_base_d  = bus.ub_base_i;
          shift_d    = bus.shift_i;
          relu_d     = bus.relu_en_i;
          state_d    = (rows_clamped == 8'd0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        cyc_d = cyc_q + 9'd1;
        if (cyc_q == ({1'b0, num_rows_q} + 9'd30)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        cyc_d = cyc_q + 9'd1;
        if (cyc_q == ({1'b0, num_rows_q} + 9'd32)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    wr_en_d   = row_valid;
    ub_addr_d = '0;
    ub_data_d = '0;
    if (row_valid) begin
      ub_addr_d = ub_base_q + row_idx[6:0];
      for (int k = 0; k < LANES; k++) begin
        ub_data_d[k] = activate(aligned[k], shift_q, relu_q);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cyc_q      <= '0;
      num_rows_q <= '0;
      acc_base_q <= '0;
      ub_base_q  <= '0;
      shift_q    <= '0;
      relu_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      ub_addr_q  <= '0;
      ub_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      num_rows_q <= num_rows_d;
      acc_base_q <= acc_base_d;
      ub_base_q  <= ub_base_d;
      shift_q    <= shift_d;
      relu_q     <= relu_d;
      wr_en_q    <= wr_en_d;
      ub_addr_q  <= ub_addr_d;
      ub_data_q  <= ub_data_d;
    end
  end

  assign bus.acc_rd_en_o   = rd_active;
  assign bus.acc_addr_rd_o = rd_active ? (acc_base_q + cyc_q[6:0]) : 7'd0;
  assign bus.ub_wr_en_o    = wr_en_q;
  assign bus.ub_addr_o     = ub_addr_q;
  assign bus.ub_data_o     = ub_data_q;
  assign bus.busy_o        = (state_q == S_READ) || (state_q == S_DRAIN);
  assign bus.done_o        = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_accumulator_readout.sv
`default_nettype none
// ============================================================================
// tb_accumulator_readout: scoreboard bench for accumulator_readout
// Rev 1.0
// ============================================================================
module tb_accumulator_readout;
  import tpu_package::*;

  localparam int OUT_WIDTH = 8;
  localparam int LANES     = 32;

  typedef logic [RES_WIDTH:0] lane_t;
  typedef logic [LANES-1:0][OUT_WIDTH-1:0] row_t;
  typedef struct {
    int         cyc;
    logic [6:0] addr;
    row_t       data;
  } wr_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   mon_en   = 1'b0;

  int   mem [128][LANES];
  int   vals [4] = '{1000, 2000, -40, -5000};

  logic [6:0] hist_a [33];
  bit         hist_v [33];

  bit         m_job = 1'b0;
  int         m_c0, m_n, m_done_cyc;
  logic [6:0] m_acc, m_ub;
  int         m_sh;
  bit         m_relu;
  wr_t        sb [$];

  accumulator_readout_if #(.OUT_WIDTH(OUT_WIDTH)) bus ();

  accumulator_readout #(.OUT_WIDTH(OUT_WIDTH)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [511:0] act_v, input logic [511:0] exp_v);
    n_checks++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, act_v, exp_v);
    end
  endtask

  function automatic logic [OUT_WIDTH-1:0] act(input int v, input int sh, input bit relu);
    longint x, y, lim;
    lim = longint'(1) << (OUT_WIDTH - 1);
    x   = (relu && v < 0) ? 64'sd0 : longint'(v);
    y   = x >>> sh;
    if (y > lim - 1) y = lim - 1;
    else if (y < -lim) y = -lim;
    return y[OUT_WIDTH-1:0];
  endfunction

  // Accumulator memory model: one-cycle latency, lane k lags lane 0 by k cycles.
  always @(negedge clk_i) begin
    for (int i = 32; i > 0; i--) begin
      hist_a[i] = hist_a[i-1];
      hist_v[i] = hist_v[i-1];
    end
    hist_a[0] = bus.acc_addr_rd_o;
    hist_v[0] = (bus.acc_rd_en_o === 1'b1);
  end

  always @(posedge clk_i) begin
    #1;
    for (int k = 0; k < LANES; k++) begin
      bus.acc_data_i[k] = hist_v[k] ? lane_t'(mem[hist_a[k]][k]) : lane_t'($urandom);
    end
  end

  // Monitor: compare this cycle's outputs with the job model, then update the model.
  always @(negedge clk_i) begin
    int         rel;
    bit         rd_exp, busy_exp, done_exp;
    logic [6:0] a_exp;
    wr_t        e;
    if (mon_en) begin
      rel      = cyc - m_c0;
      rd_exp   = m_job && (m_n > 0) && (rel >= 0) && (rel <= m_n + 30);
      busy_exp = m_job && (m_n > 0) && (rel >= 0) && (rel <= m_n + 32);
      done_exp = m_job && (cyc == m_done_cyc);
      a_exp    = rd_exp ? (m_acc + 7'(rel)) : 7'd0;
      chk("rd_en", bus.acc_rd_en_o, rd_exp);
      chk("rd_addr", bus.acc_addr_rd_o, a_exp);
      chk("busy", bus.busy_o, busy_exp);
      chk("done", bus.done_o, done_exp);
      if (bus.ub_wr_en_o === 1'b1) begin
        if (sb.size() == 0) begin
          chk("wr_unexpected", bus.ub_wr_en_o, 1'b0);
        end else begin
          e = sb.pop_front();
          chk("wr_cycle", cyc, e.cyc);
          chk("wr_addr", bus.ub_addr_o, e.addr);
          chk("wr_data", bus.ub_data_o, e.data);
        end
      end else begin
        chk("wr_en_known", bus.ub_wr_en_o, 1'b0);
        chk("idle_addr", bus.ub_addr_o, 7'd0);
        chk("idle_data", bus.ub_data_o, row_t'(0));
        if (sb.size() > 0 && sb[0].cyc <= cyc) begin
          chk("wr_missing", bus.ub_wr_en_o, 1'b1);
          void'(sb.pop_front());
        end
      end

      if (rst_i) begin
        m_job = 1'b0;
        sb.delete();
      end else if ((!m_job || cyc > m_done_cyc) && bus.start_i) begin
        m_job      = 1'b1;
        m_c0       = cyc + 1;
        m_n        = (bus.num_rows_i > 8'd128) ? 128 : int'(bus.num_rows_i);
        m_acc      = bus.acc_base_i;
        m_ub       = bus.ub_base_i;
        m_sh       = int'(bus.shift_i);
        m_relu     = bus.relu_en_i;
        m_done_cyc = (m_n > 0) ? m_c0 + m_n + 33 : m_c0;
        for (int j = 0; j < m_n; j++) begin
          logic [6:0] ra;
          row_t       d;
          ra = m_acc + 7'(j);
          for (int k = 0; k < LANES; k++) begin
            d[k] = act(mem[ra][k], m_sh, m_relu);
          end
          e.cyc  = m_c0 + j + 33;
          e.addr = m_ub + 7'(j);
          e.data = d;
          sb.push_back(e);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic drive_cfg(input int n, input int ab, input int ub, input int sh, input bit relu);
    bus.num_rows_i = 8'(n);
    bus.acc_base_i = 7'(ab);
    bus.ub_base_i  = 7'(ub);
    bus.shift_i    = 5'(sh);
    bus.relu_en_i  = relu;
  endtask

  // Pulses start for one cycle, then scrambles the config inputs.
  task automatic start_job(input int n, input int ab, input int ub, input int sh, input bit relu);
    drive_cfg(n, ab, ub, sh, relu);
    bus.start_i = 1'b1;
    tick(1);
    bus.start_i = 1'b0;
    drive_cfg(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
              int'($urandom_range(0, 127)), int'($urandom_range(0, 31)), 1'($urandom));
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (sb.size() == 0 && (!m_job || cyc > m_done_cyc)) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    chk("job_timeout", ok, 1'b1);
    tick(2);
  endtask

  initial begin
    bus.start_i    = 1'b0;
    bus.acc_data_i = '0;
    drive_cfg(0, 0, 0, 0, 1'b0);
    for (int j = 0; j < 128; j++)
      for (int k = 0; k < LANES; k++)
        mem[j][k] = int'($urandom_range(0, 2000000)) - 1000000;

    tick(3);
    rst_i  = 1'b0;
    mon_en = 1'b1;
    tick(3);

    // Deskew: row j lane k = j*32+k
    for (int j = 0; j < 4; j++)
      for (int k = 0; k < LANES; k++)
        mem[j][k] = j * 32 + k;
    start_job(4, 0, 10, 0, 1'b0);
    wait_idle();

    // Arithmetic and ReLU on 1000/2000/-40/-5000
    for (int j = 0; j < 4; j++)
      for (int k = 0; k < LANES; k++)
        mem[40 + j][k] = vals[(k + j) % 4];
    start_job(4, 40, 20, 3, 1'b0);
    wait_idle();
    start_job(4, 40, 20, 3, 1'b1);
    wait_idle();

    // Address wrap on both ports
    start_job(3, 126, 127, 0, 1'b0);
    wait_idle();

    // Zero-row job
    start_job(0, 5, 5, 0, 1'b0);
    wait_idle();

    // start held high across several jobs
    drive_cfg(2, 60, 70, 1, 1'b0);
    bus.start_i = 1'b1;
    tick(80);
    bus.start_i = 1'b0;
    wait_idle();

    // Reset in cycle 20 of an 8-row job, then a 1-row job right after release
    start_job(8, 90, 30, 2, 1'b0);
    tick(20);
    rst_i = 1'b1;
    tick(1);
    rst_i = 1'b0;
    start_job(1, 7, 99, 4, 1'b1);
    wait_idle();

    // Row count clamp and random jobs
    start_job(200, 17, 3, 5, 1'b0);
    wait_idle();
    for (int t = 0; t < 3; t++) begin
      start_job(int'($urandom_range(1, 20)), int'($urandom_range(0, 127)),
                int'($urandom_range(0, 127)), int'($urandom_range(0, 31)), 1'($urandom));
      wait_idle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
